// File: rtl/micom_spi_master.sv
// micom_spi_master: SPI mode-0 frame initiator for a micom_connect-style slave.
// One frame is one spi_cs_n-low window carrying len bytes (opcode first).
// Bytes arrive on a tx valid/ready handshake and leave on an rx valid pulse.
// Optional build macro MICOM_SPI_ACK_CHECK_EN: the byte received in the opcode
// slot is compared with 8'hA5 and a mismatch sets the sticky ack_error flag.
// CS_SETUP and CS_HOLD are expected to be at least 1; BYTE_GAP may be 0.
module micom_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int BYTE_GAP = 2,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             spi_cs_n,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             ack_error
);

    localparam int CNT_W    = 16;
    localparam int GAP_LOAD = (BYTE_GAP > 0) ? BYTE_GAP - 1 : 0;

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, BIT_LO, BIT_HI, GAP, HOLD, FIN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [LEN_W-1:0] bytes_reg, bytes_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             cs_n_reg, cs_n_next;
    logic             sclk_reg, sclk_next;
    logic             mosi_reg, mosi_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             accept;
    logic             byte_end;

    // A frame starts only from IDLE with a non-zero length; a byte ends on the
    // last cycle of the eighth high phase.
    assign accept   = (state_reg == IDLE) && start && (len != '0);
    assign byte_end = (state_reg == BIT_HI) && (cnt_reg == '0) && (bit_reg == 3'd7);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        bytes_next    = bytes_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        cs_n_next     = cs_n_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        rx_valid_next = 1'b0;
        tx_ready      = 1'b0;

        if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_next = SETUP;
                        cs_n_next  = 1'b0;
                        busy_next  = 1'b1;
                        bytes_next = len;
                        cnt_next   = CNT_W'(CS_SETUP - 1);
                    end else begin
                        // Empty frame: report completion without touching CS.
                        state_next = FIN;
                        done_next  = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Stalls here with spi_clk low for as long as the host needs.
                if (tx_valid) begin
                    tx_ready      = 1'b1;
                    tx_shift_next = tx_data;
                    mosi_next     = tx_data[7];
                    bytes_next    = bytes_reg - 1'b1;
                    bit_next      = 3'd0;
                    cnt_next      = CNT_W'(CLK_DIV - 1);
                    state_next    = BIT_LO;
                end
            end
            BIT_LO: begin
                if (cnt_reg == '0) begin
                    sclk_next  = 1'b1;
                    cnt_next   = CNT_W'(CLK_DIV - 1);
                    state_next = BIT_HI;
                end
            end
            BIT_HI: begin
                // Capture miso on the first cycle of the high phase.
                if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
                    rx_shift_next = {rx_shift_reg[6:0], spi_miso};
                end
                if (cnt_reg == '0) begin
                    sclk_next = 1'b0;
                    cnt_next  = CNT_W'(CLK_DIV - 1);
                    if (bit_reg != 3'd7) begin
                        // mosi moves on the same edge that drops spi_clk.
                        bit_next      = bit_reg + 3'd1;
                        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        mosi_next     = tx_shift_reg[6];
                        state_next    = BIT_LO;
                    end else begin
                        rx_valid_next = 1'b1;
                        rx_data_next  = rx_shift_reg;
                        if (bytes_reg != '0) begin
                            if (BYTE_GAP == 0) begin
                                state_next = LOAD;
                            end else begin
                                cnt_next   = CNT_W'(GAP_LOAD);
                                state_next = GAP;
                            end
                        end else begin
                            cnt_next   = CNT_W'(CS_HOLD - 1);
                            state_next = HOLD;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = LOAD;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) begin
                    cs_n_next  = 1'b1;
                    done_next  = 1'b1;
                    mosi_next  = 1'b0;
                    state_next = FIN;
                end
            end
            FIN: begin
                // busy drops one cycle after the done pulse.
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= 3'd0;
            bytes_reg    <= '0;
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
            cs_n_reg     <= 1'b1;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            bytes_reg    <= bytes_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            cs_n_reg     <= cs_n_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign spi_cs_n = cs_n_reg;
    assign spi_clk  = sclk_reg;
    assign spi_mosi = mosi_reg;

`ifdef MICOM_SPI_ACK_CHECK_EN
    logic first_reg;
    logic ack_err_reg;

    // Track the opcode slot and latch a bad slave acknowledge until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_reg   <= 1'b0;
            ack_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                first_reg <= 1'b1;
            end else if (byte_end) begin
                first_reg <= 1'b0;
                if (first_reg && (rx_shift_reg != 8'hA5)) begin
                    ack_err_reg <= 1'b1;
                end
            end
        end
    end

    assign ack_error = ack_err_reg;
`else
    logic unused_ok;
    assign unused_ok = accept & byte_end;
    assign ack_error = 1'b0;
`endif

endmodule

// File: tb/tb_micom_spi_master.sv
// Bench for micom_spi_master: a mode-0 slave model answers each frame from a
// response table, a monitor collects rx bytes, done pulses and CS-low time,
// and every frame is compared with values derived from the frame description.
module tb_micom_spi_master;

    localparam int LEN_W    = 16;
    localparam int BYTE_GAP = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             done;
    logic             spi_cs_n;
    logic             spi_clk;
    logic             spi_mosi;
    logic             spi_miso;
    logic             ack_error;

    micom_spi_master #(
        .CLK_DIV (4),
        .CS_SETUP(2),
        .CS_HOLD (2),
        .BYTE_GAP(BYTE_GAP),
        .LEN_W   (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .done     (done),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .ack_error(ack_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Slave model state
    logic [7:0] resp [0:15];
    logic [7:0] mosi_cap [0:15];
    int         sl_bit = 0;
    int         rises = 0;

    // Monitor state
    logic [7:0] rx_q [$];
    int         cs_low = 0;
    int         done_cnt = 0;
    int         mosi_bad = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;

    typedef struct {
        int               n;
        logic [3:0][7:0]  tx;
        logic [3:0][7:0]  rs;
        int               stall_idx;
        int               poke;
        int               exp_cs;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Mode-0 slave: first bit ready at CS fall, next bit after every falling spi_clk.
    always @(negedge spi_cs_n) begin
        sl_bit   = 0;
        spi_miso = resp[0][7];
    end

    always @(posedge spi_clk) begin
        if (!spi_cs_n) begin
            mosi_cap[(rises / 8) % 16][7 - (rises % 8)] = spi_mosi;
            rises++;
        end
    end

    always @(negedge spi_clk) begin
        if (!spi_cs_n) begin
            sl_bit++;
            spi_miso = resp[(sl_bit / 8) % 16][7 - (sl_bit % 8)];
        end
    end

    // Sample DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (!spi_cs_n) cs_low++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt++;
        if (spi_clk && prev_sclk && (spi_mosi != prev_mosi)) mosi_bad++;
        prev_sclk = spi_clk;
        prev_mosi = spi_mosi;
    end

    task automatic clear_mon();
        rises    = 0;
        cs_low   = 0;
        done_cnt = 0;
        mosi_bad = 0;
        rx_q.delete();
    endtask

    task automatic do_frame(input int n, input logic [3:0][7:0] tx, input logic [3:0][7:0] rs,
                            input int stall_idx, input int poke, input int exp_cs, input string tag);
        int   stall_bad;
        int   got_done;
        logic consumed;
        stall_bad = 0;
        for (int i = 0; i < 16; i++) resp[i] = 8'h00;
        for (int i = 0; i < 4; i++) resp[i] = rs[i];
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                tx_valid = 1'b0;
                for (int w = 0; w < 5000 && rx_q.size() < i; w++) @(negedge clk);
                repeat (20) begin
                    @(negedge clk);
                    if (spi_clk || spi_cs_n) stall_bad++;
                end
            end
            tx_data  = tx[i];
            tx_valid = 1'b1;
            consumed = 1'b0;
            for (int w = 0; w < 5000 && !consumed; w++) begin
                #1;
                consumed = tx_ready;
                @(negedge clk);
            end
            check({tag, " tx_consumed"}, int'(consumed), 1);
            if (i == poke) begin
                start = 1'b1;
                len   = 16'd5;
                @(negedge clk);
                start = 1'b0;
            end
        end
        tx_valid = 1'b0;
        got_done = 0;
        for (int w = 0; w < 5000 && got_done == 0; w++) begin
            @(negedge clk);
            got_done = int'(done);
        end
        check({tag, " done_seen"}, got_done, 1);
        check({tag, " cs_at_done"}, int'(spi_cs_n), 1);
        repeat (3) @(negedge clk);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " rx_cnt"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check({tag, " rx_byte"}, int'(rx_q[i]), int'(rs[i]));
            check({tag, " mosi_byte"}, int'(mosi_cap[i]), int'(tx[i]));
        end
        check({tag, " sclk_rises"}, rises, 8 * n);
        if (exp_cs >= 0) check({tag, " cs_low_cycles"}, cs_low, exp_cs);
        if (stall_idx >= 0) check({tag, " stall_sclk_low"}, stall_bad, 0);
        check({tag, " mosi_stable_hi"}, mosi_bad, 0);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " cs_after"}, int'(spi_cs_n), 1);
`ifndef MICOM_SPI_ACK_CHECK_EN
        check({tag, " ack_error"}, int'(ack_error), 0);
`endif
        $display("frame %s len=%0d rx_cnt=%0d cs_low=%0d rises=%0d", tag, n, rx_q.size(), cs_low, rises);
    endtask

    initial begin
        int               got;
        int               n;
        logic [3:0][7:0]  tx;
        logic [3:0][7:0]  rs;

        vecs[0] = '{1, 32'h0000_0002, 32'h0000_00A5, -1, -1, 69};
        vecs[1] = '{3, 32'h0067_0503, 32'h003C_5AA5,  1, -1, -1};
        vecs[2] = '{3, 32'h00F0_0F81, 32'h0000_FFA5, -1, -1, 203};
        vecs[3] = '{2, 32'h0000_7EC3, 32'h0000_12A5, -1, -1, 136};
        vecs[4] = '{1, 32'h0000_0055, 32'h0000_00A5, -1,  0, 69};

        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        spi_miso = 1'b0;
        for (int i = 0; i < 16; i++) begin
            resp[i]     = 8'h00;
            mosi_cap[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check("rst cs_n", int'(spi_cs_n), 1);
        check("rst sclk", int'(spi_clk), 0);
        check("rst mosi", int'(spi_mosi), 0);
        check("rst busy", int'(busy), 0);
        check("rst tx_ready", int'(tx_ready), 0);
        check("rst rx_valid", int'(rx_valid), 0);
        check("rst done", int'(done), 0);
        check("rst rx_data", int'(rx_data), 0);
        check("rst ack_error", int'(ack_error), 0);
        $display("reset state checked");
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            do_frame(vecs[v].n, vecs[v].tx, vecs[v].rs, vecs[v].stall_idx, vecs[v].poke,
                     vecs[v].exp_cs, $sformatf("vec%0d", v));
        end

        // Empty frame: done without any CS activity
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
        got   = done_cnt + int'(done);
        repeat (4) @(negedge clk);
        check("len0 done_cnt", done_cnt, 1);
        check("len0 cs_low", cs_low, 0);
        check("len0 rises", rises, 0);
        check("len0 busy", int'(busy), 0);
        $display("frame len0 done_cnt=%0d cs_low=%0d", done_cnt, cs_low);

        // Reset during bit 4 of byte 2
        for (int i = 0; i < 16; i++) resp[i] = 8'hA5;
        clear_mon();
        @(negedge clk);
        start    = 1'b1;
        len      = 16'd3;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        for (int w = 0; w < 5000 && got == 0; w++) begin
            @(negedge clk);
            if (rises >= 12) got = 1;
        end
        check("midrst reached", got, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst cs_n", int'(spi_cs_n), 1);
        check("midrst sclk", int'(spi_clk), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst mosi", int'(spi_mosi), 0);
        tx_valid = 1'b0;
        reset    = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst rx_cnt", rx_q.size(), 1);
        check("midrst done_cnt", done_cnt, 0);
        check("midrst idle_cs", int'(spi_cs_n), 1);
        $display("reset mid-frame rx_cnt=%0d done_cnt=%0d", rx_q.size(), done_cnt);
        do_frame(vecs[2].n, vecs[2].tx, vecs[2].rs, -1, -1, vecs[2].exp_cs, "after_rst");

        // Randomized frames against arithmetic model of frame timing
        for (int r = 0; r < 20; r++) begin
            n     = int'($urandom_range(1, 4));
            tx    = $urandom;
            rs    = $urandom;
            rs[0] = 8'hA5;
            do_frame(n, tx, rs, -1, -1, 4 + 65 * n + BYTE_GAP * (n - 1), $sformatf("rnd%0d", r));
        end

`ifdef MICOM_SPI_ACK_CHECK_EN
        do_frame(1, 32'h0000_0002, 32'h0000_0000, -1, -1, 69, "ack_bad");
        check("ack set", int'(ack_error), 1);
        do_frame(2, 32'h0000_3302, 32'h0000_44A5, -1, -1, 136, "ack_good");
        check("ack sticky", int'(ack_error), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
